mem_stream_master: RTL and testbench
====================================

Name: mem_stream_master

Overview:
- Synthesizable initiator on the byte-wide off-chip memory bus: the Mout_*/M_* signals that the simulation memory model answers.
- Executes one block command at a time.
  - Read mode: copies LEN bytes starting at BASE from memory to an output valid/ready stream.
  - Write mode: copies LEN bytes from an input valid/ready stream to memory starting at BASE.
- Used to preload kernel inputs and drain kernel results in on-board harnesses, in place of the simulation-only memory loader.

Parameters:
ADDR_W, 10, memory bus address width (bytes)
DATA_W, 8, bus data width; fixed at 8 for this revision
LEN_W, 11, transfer length counter width; max LEN = 2**LEN_W-1
TIMEOUT_CYC, 64, cycles to wait for M_DataRdy before abort (used only with MEM_TIMEOUT_EN)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous, active-low reset
cmd_start  in  1  pulse; accepted only in IDLE
cmd_dir  in  1  0 = read (mem->stream), 1 = write (stream->mem)
cmd_base  in  ADDR_W  start byte address
cmd_len  in  LEN_W  byte count
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at command end
error  out  1  sticky abort flag, cleared by next accepted start
s_out_data  out  8  read-mode stream data
s_out_valid  out  1  read-mode stream valid
s_out_ready  in  1  read-mode stream ready
s_in_data  in  8  write-mode stream data
s_in_valid  in  1  write-mode stream valid
s_in_ready  out  1  write-mode stream ready
Mout_oe_ram  out  1  read request
Mout_we_ram  out  1  write request
Mout_addr_ram  out  ADDR_W  byte address
Mout_Wdata_ram  out  8  write data
Mout_data_ram_size  out  4  access size in bits; constant 8 while a request is up, else 0
M_Rdata_ram  in  8  read data, valid when M_DataRdy is high with oe
M_DataRdy  in  1  request completion

Behaviour:
- Reset (synchronous, reset==0 at rising edge):
  - State goes to IDLE.
  - All outputs go to 0: oe, we, addr, Wdata, size, busy, done, error, s_out_valid, s_out_data, s_in_ready.
  - Reset mid-transfer abandons the transfer at that edge; no done pulse.
- FSM states: IDLE, RD_REQ, RD_OUT, WR_WAIT, WR_REQ, FIN.
- IDLE:
  - On cmd_start, latch base/len/dir and clear error.
  - If len==0, go to FIN.
  - Otherwise go to RD_REQ (dir=0) or WR_WAIT (dir=1).
  - cmd_start in any other state is ignored.
- RD_REQ:
  - Drive oe=1 and addr=cur_addr; hold both stable until M_DataRdy.
  - On M_DataRdy: capture M_Rdata_ram into s_out_data, drop oe, go to RD_OUT.
- RD_OUT:
  - s_out_valid=1; data stays stable until s_out_ready.
  - On handshake: addr+1, rem-1.
  - If rem==1, go to FIN; else go to RD_REQ.
  - A request is issued only after the previous byte is consumed, so the master has at most one outstanding request and never stalls the bus during output backpressure.
- WR_WAIT:
  - s_in_ready=1.
  - On s_in_valid: latch s_in_data into Wdata, go to WR_REQ.
- WR_REQ:
  - Drive we=1 with addr/Wdata held stable until M_DataRdy.
  - On M_DataRdy: drop we, addr+1, rem-1.
  - If rem==1, go to FIN; else go to WR_WAIT.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Address arithmetic: cur_addr increments modulo 2**ADDR_W (wraps 0x3FF->0x000 silently). rem is LEN_W bits.
- Bus rules:
  - oe and we are never high together.
  - M_DataRdy is ignored outside RD_REQ/WR_REQ.
  - M_DataRdy in the same cycle a request is first raised is legal and completes it (write-delay-1 responders do this).
- Throughput against a responder with read delay 2 / write delay 1, stream always ready:
  - Read: 3 cycles/byte (2 in RD_REQ + 1 in RD_OUT).
  - Write: 2 cycles/byte (1 in WR_WAIT + 1 in WR_REQ).

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in RD_REQ/WR_REQ without M_DataRdy.
  - On reaching TIMEOUT_CYC: drop oe/we, set error=1, go to FIN (done still pulses).
  - Remaining bytes are not transferred.
- Undefined: no counter, error is tied 0, and the master waits indefinitely.

Decomposition:
- Shared package mem_bus_pkg:
  - FSM state enum.
  - Constants: BUS_SIZE_BYTE=4'd8, DIR_READ=1'b0, DIR_WRITE=1'b1.
  - Default ADDR_W/LEN_W values, reused by the simulation memory model.
- Sub-module mem_req_ctrl:
  - Owns oe/we/addr/Wdata hold-until-DataRdy and the optional watchdog.
  - Exposes a req/ack pulse pair to the top FSM.

Test Plan:
- Read, base=0x010, len=4, memory bytes 0xA1..0xA4, responder delay R2/W1, ready=1 -> stream A1,A2,A3,A4; addrs 0x010..0x013; done pulse exactly 12 cycles after busy rises.
- Write, base=0x3FE, len=3, stream 0x11,0x22,0x33 -> mem[0x3FE]=0x11, mem[0x3FF]=0x22, mem[0x000]=0x33 (wrap); we never coincides with oe.
- Read with s_out_ready low for 5 cycles on byte 2 -> s_out_data held stable, no oe asserted during stall, bytes neither lost nor duplicated.
- len=0 with start -> done the next cycle, no bus activity; cmd_start while busy -> ignored, transfer unaffected.
- reset=0 asserted mid-write (byte 2 of 4) -> all outputs 0 at the next edge, no done pulse; a new command after release runs normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=8, responder never returns DataRdy -> oe drops after 8 cycles, error=1, done pulses; next start clears error.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the byte-wide off-chip memory bus master and its simulation memory model.
package mem_bus_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 11;

  localparam logic [3:0] BUS_SIZE_BYTE = 4'd8;
  localparam logic       DIR_READ      = 1'b0;
  localparam logic       DIR_WRITE     = 1'b1;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_OUT, WR_WAIT, WR_REQ, FIN
  } msm_state_e;
endpackage

// File: rtl/mem_stream_master_if.sv
// Off-chip memory bus (Mout_*/M_*): master drives requests, slave (memory model) answers.
interface mem_stream_master_if #(
  parameter int ADDR_W = mem_bus_pkg::ADDR_W_DEF
);
  logic              Mout_oe_ram;
  logic              Mout_we_ram;
  logic [ADDR_W-1:0] Mout_addr_ram;
  logic [7:0]        Mout_Wdata_ram;
  logic [3:0]        Mout_data_ram_size;
  logic [7:0]        M_Rdata_ram;
  logic              M_DataRdy;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  M_Rdata_ram, M_DataRdy
  );
  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output M_Rdata_ram, M_DataRdy
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Single-request bus driver: holds oe/we/addr/Wdata until M_DataRdy, acks the FSM.
// MEM_TIMEOUT_EN adds a watchdog that abandons a request after TIMEOUT_CYC cycles.
module mem_req_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 8
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                clock,
  input  logic                reset,
  mem_stream_master_if.master mem,
  input  logic                req,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                ack,
  output logic                timeout
);
  logic active;
  logic is_wr;

  // req is raised on the FSM transition into a request state, so the bus
  // request is already up in that state's first cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      active              <= 1'b0;
      is_wr               <= 1'b0;
      mem.Mout_addr_ram   <= '0;
      mem.Mout_Wdata_ram  <= '0;
    end else if (req) begin
      active            <= 1'b1;
      is_wr             <= req_we;
      mem.Mout_addr_ram <= req_addr;
      if (req_we) mem.Mout_Wdata_ram <= req_wdata;
    end else if (ack || timeout) begin
      active <= 1'b0;
    end
  end

  assign ack                    = active & mem.M_DataRdy;
  assign mem.Mout_oe_ram        = active & ~is_wr;
  assign mem.Mout_we_ram        = active &  is_wr;
  assign mem.Mout_data_ram_size = active ? BUS_SIZE_BYTE : 4'd0;

`ifdef MEM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clock) begin
    if (!reset || req)                 wd_cnt <= '0;
    else if (active && !mem.M_DataRdy) wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout = active & ~mem.M_DataRdy & (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: rtl/mem_stream_master.sv
// Block copy engine between the memory bus and valid/ready byte streams, one command at a time.
// Optional MEM_TIMEOUT_EN: abort a stuck bus request and flag error.
module mem_stream_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = 8,
  parameter int LEN_W  = LEN_W_DEF
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_start,
  input  logic                cmd_dir,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DATA_W-1:0]   s_out_data,
  output logic                s_out_valid,
  input  logic                s_out_ready,
  input  logic [DATA_W-1:0]   s_in_data,
  input  logic                s_in_valid,
  output logic                s_in_ready,
  mem_stream_master_if.master mem
);
  msm_state_e        state, state_nx;
  logic [ADDR_W-1:0] cur_addr, req_addr;
  logic [LEN_W-1:0]  rem;
  logic              req, req_we, ack, timeout, last;

  mem_req_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) u_req (
    .clock(clock), .reset(reset), .mem(mem),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(s_in_data),
    .ack(ack), .timeout(timeout)
  );

  assign last = (rem == LEN_W'(1));

  always_comb begin
    state_nx    = state;
    req         = 1'b0;
    req_we      = 1'b0;
    req_addr    = cur_addr;
    busy        = 1'b0;
    done        = 1'b0;
    s_out_valid = 1'b0;
    s_in_ready  = 1'b0;
    case (state)
      IDLE: if (cmd_start) begin
        if (cmd_len == '0)            state_nx = FIN;
        else if (cmd_dir == DIR_WRITE) state_nx = WR_WAIT;
        else begin
          state_nx = RD_REQ;
          req      = 1'b1;
          req_addr = cmd_base;
        end
      end
      RD_REQ: begin
        busy = 1'b1;
        if (ack)          state_nx = RD_OUT;
        else if (timeout) state_nx = FIN;
      end
      // Next read is issued only once this byte is taken: one outstanding request max.
      RD_OUT: begin
        busy        = 1'b1;
        s_out_valid = 1'b1;
        if (s_out_ready) begin
          if (last) state_nx = FIN;
          else begin
            state_nx = RD_REQ;
            req      = 1'b1;
            req_addr = cur_addr + 1'b1;
          end
        end
      end
      WR_WAIT: begin
        busy       = 1'b1;
        s_in_ready = 1'b1;
        if (s_in_valid) begin
          state_nx = WR_REQ;
          req      = 1'b1;
          req_we   = 1'b1;
        end
      end
      WR_REQ: begin
        busy = 1'b1;
        if (ack)          state_nx = last ? FIN : WR_WAIT;
        else if (timeout) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      cur_addr   <= '0;
      rem        <= '0;
      s_out_data <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (cmd_start) begin
          cur_addr <= cmd_base;
          rem      <= cmd_len;
        end
        RD_REQ: if (ack) s_out_data <= mem.M_Rdata_ram;
        RD_OUT: if (s_out_ready) begin
          cur_addr <= cur_addr + 1'b1;
          rem      <= rem - 1'b1;
        end
        WR_REQ: if (ack) begin
          cur_addr <= cur_addr + 1'b1;
          rem      <= rem - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (!reset)                          error <= 1'b0;
    else if (state == IDLE && cmd_start) error <= 1'b0;
    else if (timeout)                    error <= 1'b1;
  end
`else
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_mem_stream_master.sv
// Directed bench for mem_stream_master against a read-delay-2 / write-delay-1 memory model.
module tb_mem_stream_master;
  import mem_bus_pkg::*;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_start = 1'b0, cmd_dir = 1'b0;
  logic [AW-1:0] cmd_base = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          busy, done, error;
  logic [7:0]    s_out_data;
  logic          s_out_valid;
  logic          s_out_ready = 1'b1;
  logic [7:0]    s_in_data = '0;
  logic          s_in_valid = 1'b0;
  logic          s_in_ready;

  mem_stream_master_if #(.ADDR_W(AW)) mem ();

  mem_stream_master #(
    .ADDR_W(AW), .DATA_W(8), .LEN_W(LW)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .busy(busy), .done(done), .error(error),
    .s_out_data(s_out_data), .s_out_valid(s_out_valid), .s_out_ready(s_out_ready),
    .s_in_data(s_in_data), .s_in_valid(s_in_valid), .s_in_ready(s_in_ready),
    .mem(mem)
  );

  always #5 clock = ~clock;

  // Memory model: read completes in the 2nd cycle of oe, write in the 1st cycle of we.
  logic [7:0]    ram [0:1023];
  int            age = 0;
  logic          mute = 1'b0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [7:0]    pre_data = '0;

  assign mem.M_DataRdy   = !mute && (mem.Mout_we_ram || (mem.Mout_oe_ram && age >= 1));
  assign mem.M_Rdata_ram = ram[mem.Mout_addr_ram];

  always @(posedge clock) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem.Mout_we_ram && mem.M_DataRdy) ram[mem.Mout_addr_ram] <= mem.Mout_Wdata_ram;
    if ((mem.Mout_oe_ram || mem.Mout_we_ram) && !mem.M_DataRdy) age <= age + 1;
    else age <= 0;
  end

  // Monitor at the falling edge: values here are what the next rising edge sees.
  logic [7:0]    rxq [$];
  logic [AW-1:0] aq  [$];
  int n_both = 0, n_done = 0, n_busy = 0, n_oe = 0, n_we = 0;
  always @(negedge clock) begin
    if (s_out_valid && s_out_ready) rxq.push_back(s_out_data);
    if ((mem.Mout_oe_ram || mem.Mout_we_ram) && mem.M_DataRdy) aq.push_back(mem.Mout_addr_ram);
    if (mem.Mout_oe_ram && mem.Mout_we_ram) n_both++;
    if (done) n_done++;
    if (busy) n_busy++;
    if (mem.Mout_oe_ram) n_oe++;
    if (mem.Mout_we_ram) n_we++;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic start(input logic dir, input logic [AW-1:0] base, input logic [LW-1:0] len);
    cmd_dir = dir; cmd_base = base; cmd_len = len; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 50 && !s_out_valid; k++) tick();
    chk("out_valid_seen", 32'(s_out_valid), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    s_in_valid = 1'b1;
    s_in_data  = b;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clock);
      ok = s_in_ready;
      @(posedge clock);
      #1;
    end
    chk("in_handshake", 32'(ok), 32'd1);
  endtask

  typedef struct packed {
    logic          dir;
    logic [AW-1:0] base;
    int            len;
    logic [31:0]   d;         // byte i at d[8*i +: 8]
    int            exp_busy;
  } vec_t;

  vec_t tv [5];

  initial begin
    int n, rx0, a0, b0, d0, w0, o0;
    vec_t v;
    logic [AW-1:0] ea;
    logic [7:0]    eb;

    tv[0] = '{dir: 1'b0, base: 10'h010, len: 4, d: 32'hA4A3A2A1, exp_busy: 12};
    tv[1] = '{dir: 1'b1, base: 10'h3FE, len: 3, d: 32'h00332211, exp_busy: 6};
    tv[2] = '{dir: 1'b0, base: 10'h3FF, len: 2, d: 32'h0000C35A, exp_busy: 6};
    tv[3] = '{dir: 1'b1, base: 10'h100, len: 1, d: 32'h0000007E, exp_busy: 2};
    tv[4] = '{dir: 1'b0, base: 10'h200, len: 1, d: 32'h000000FF, exp_busy: 3};

    tick(); tick();
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_oe",    32'(mem.Mout_oe_ram), 32'd0);
    chk("rst_size",  32'(mem.Mout_data_ram_size), 32'd0);
    chk("rst_inrdy", 32'(s_in_ready), 32'd0);
    reset = 1'b1;
    tick();

    for (int t = 0; t < 5; t++) begin
      v = tv[t];
      if (v.dir == DIR_READ)
        for (int i = 0; i < v.len; i++) preload(AW'(v.base + AW'(i)), v.d[8*i +: 8]);
      rx0 = rxq.size(); a0 = aq.size(); b0 = n_busy; d0 = n_done;
      s_out_ready = 1'b1;
      start(v.dir, v.base, LW'(v.len));
      if (v.dir == DIR_WRITE) begin
        for (int i = 0; i < v.len; i++) send_byte(v.d[8*i +: 8]);
        s_in_valid = 1'b0;
      end
      wait_done(200, n);
      if (v.dir == DIR_READ) chk($sformatf("v%0d_done_latency", t), 32'(n), 32'(v.exp_busy));
      tick();
      chk($sformatf("v%0d_busy_cycles", t), 32'(n_busy - b0), 32'(v.exp_busy));
      chk($sformatf("v%0d_done_pulses", t), 32'(n_done - d0), 32'd1);
      chk($sformatf("v%0d_out_bytes", t), 32'(rxq.size() - rx0), (v.dir == DIR_READ) ? 32'(v.len) : 32'd0);
      chk($sformatf("v%0d_error", t), 32'(error), 32'd0);
      for (int i = 0; i < v.len; i++) begin
        ea = AW'(v.base + AW'(i));
        eb = v.d[8*i +: 8];
        chk($sformatf("v%0d_addr%0d", t, i), (a0 + i < aq.size()) ? 32'(aq[a0 + i]) : 32'hDEAD, 32'(ea));
        if (v.dir == DIR_READ)
          chk($sformatf("v%0d_rd%0d", t, i), (rx0 + i < rxq.size()) ? 32'(rxq[rx0 + i]) : 32'hDEAD, 32'(eb));
        else
          chk($sformatf("v%0d_wr%0d", t, i), 32'(ram[ea]), 32'(eb));
      end
    end

    // Output backpressure on byte 2: data held, no new bus request, nothing lost or repeated.
    preload(10'h020, 8'h31); preload(10'h021, 8'h32); preload(10'h022, 8'h33);
    rx0 = rxq.size();
    s_out_ready = 1'b0;
    start(DIR_READ, 10'h020, 11'd3);
    wait_valid();
    chk("bp_byte1", 32'(s_out_data), 32'h31);
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      chk("bp_stall_valid", 32'(s_out_valid), 32'd1);
      chk("bp_stall_data", 32'(s_out_data), 32'h32);
      chk("bp_stall_no_oe", 32'(mem.Mout_oe_ram), 32'd0);
      tick();
    end
    s_out_ready = 1'b1;
    wait_done(100, n);
    tick();
    chk("bp_count", 32'(rxq.size() - rx0), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("bp_data", (rx0 + i < rxq.size()) ? 32'(rxq[rx0 + i]) : 32'hDEAD, 32'(8'h31 + i));

    // Zero length: done next cycle, no bus traffic.
    o0 = n_oe + n_we; d0 = n_done;
    start(DIR_READ, 10'h055, 11'd0);
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    tick();
    chk("len0_done_drop", 32'(done), 32'd0);
    chk("len0_no_bus", 32'(n_oe + n_we - o0), 32'd0);
    chk("len0_one_pulse", 32'(n_done - d0), 32'd1);

    // Start while busy is ignored.
    rx0 = rxq.size(); b0 = n_busy; w0 = n_we;
    start(DIR_READ, 10'h010, 11'd4);
    tick(); tick();
    cmd_dir = DIR_WRITE; cmd_base = 10'h300; cmd_len = 11'd2; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    wait_done(100, n);
    tick();
    chk("ign_busy_cycles", 32'(n_busy - b0), 32'd12);
    chk("ign_no_write", 32'(n_we - w0), 32'd0);
    chk("ign_idle", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++)
      chk("ign_data", (rx0 + i < rxq.size()) ? 32'(rxq[rx0 + i]) : 32'hDEAD, 32'(8'hA1 + i));

    // Reset during byte 2 of a 4-byte write.
    start(DIR_WRITE, 10'h080, 11'd4);
    send_byte(8'h5C);
    send_byte(8'h6D);
    chk("mr_we_up", 32'(mem.Mout_we_ram), 32'd1);
    reset = 1'b0;
    s_in_valid = 1'b0;
    tick();
    chk("mr_oe",    32'(mem.Mout_oe_ram), 32'd0);
    chk("mr_we",    32'(mem.Mout_we_ram), 32'd0);
    chk("mr_addr",  32'(mem.Mout_addr_ram), 32'd0);
    chk("mr_wdata", 32'(mem.Mout_Wdata_ram), 32'd0);
    chk("mr_size",  32'(mem.Mout_data_ram_size), 32'd0);
    chk("mr_busy",  32'(busy), 32'd0);
    chk("mr_done",  32'(done), 32'd0);
    chk("mr_error", 32'(error), 32'd0);
    chk("mr_ovld",  32'(s_out_valid), 32'd0);
    chk("mr_odata", 32'(s_out_data), 32'd0);
    chk("mr_irdy",  32'(s_in_ready), 32'd0);
    d0 = n_done;
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    chk("mr_no_done", 32'(n_done - d0), 32'd0);
    rx0 = rxq.size();
    start(DIR_READ, 10'h080, 11'd1);
    wait_done(50, n);
    tick();
    chk("mr_after_rd", (rx0 < rxq.size()) ? 32'(rxq[rx0]) : 32'hDEAD, 32'h5C);

`ifdef MEM_TIMEOUT_EN
    // Unresponsive memory: request abandoned after 8 cycles, error sticky until next start.
    mute = 1'b1;
    o0 = n_oe; rx0 = rxq.size();
    start(DIR_READ, 10'h040, 11'd3);
    wait_done(50, n);
    chk("to_latency", 32'(n), 32'd8);
    chk("to_oe_cycles", 32'(n_oe - o0), 32'd8);
    chk("to_oe_low", 32'(mem.Mout_oe_ram), 32'd0);
    chk("to_error", 32'(error), 32'd1);
    tick();
    chk("to_error_sticky", 32'(error), 32'd1);
    chk("to_no_bytes", 32'(rxq.size() - rx0), 32'd0);
    mute = 1'b0;
    start(DIR_READ, 10'h040, 11'd0);
    chk("to_error_clear", 32'(error), 32'd0);
    tick();
`endif

    chk("oe_we_exclusive", 32'(n_both), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
